// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a length-prefixed, XOR-checksummed byte
// stream into the CPU program array and holds the CPU in reset until a good load.
//
// state | meaning
// IDLE  | after reset, CPU held in reset, waiting for load_start
// LEN   | expecting the length byte
// DATA  | writing data bytes into the array
// CSUM  | expecting the checksum byte
// RUN   | last load good, CPU released
// ERR   | last load failed its checksum, CPU held in reset
module imem_loader #(
  parameter int INST_WIDTH = 8,
  parameter int INST_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  in_valid,
  input  logic [INST_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic [INST_DEPTH-1:0] imem_addr,
  output logic [INST_WIDTH-1:0] imem_data,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [INST_DEPTH:0]   byte_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_CSUM, S_RUN, S_ERR
  } state_t;

  localparam logic [INST_DEPTH:0] LEN_FULL = {1'b1, {INST_DEPTH{1'b0}}};

  state_t                state, state_nxt;
  logic [INST_WIDTH-1:0] mem [0:(2**INST_DEPTH)-1];
  logic [INST_DEPTH:0]   len_n;
  logic [INST_DEPTH:0]   byte_cnt;
  logic [INST_DEPTH:0]   byte_cnt_inc;
  logic [INST_DEPTH-1:0] ptr;
  logic [INST_WIDTH-1:0] csum;
  logic                  accept;
  logic                  last_data;

  // All status outputs come straight from the state register.
  assign in_ready   = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
  assign busy       = in_ready;
  assign done       = (state == S_RUN);
  assign error      = (state == S_ERR);
  assign cpu_rst    = (state != S_RUN);
  assign byte_count = byte_cnt;
  assign imem_data  = mem[imem_addr];

  assign accept       = in_ready && in_valid;
  assign byte_cnt_inc = byte_cnt + 1'b1;
  assign last_data    = (byte_cnt_inc == len_n);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_RUN, S_ERR: if (load_start) state_nxt = S_LEN;
      S_LEN:  if (accept) state_nxt = S_DATA;
      S_DATA: if (accept && last_data) state_nxt = S_CSUM;
      S_CSUM: if (accept) state_nxt = (in_data == csum) ? S_RUN : S_ERR;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_n    <= '0;
      ptr      <= '0;
      csum     <= '0;
      byte_cnt <= '0;
    end else if (accept && (state == S_LEN)) begin
      // A zero length byte means a full-array image.
      len_n    <= (in_data == '0) ? LEN_FULL : (INST_DEPTH+1)'(in_data);
      ptr      <= '0;
      csum     <= '0;
      byte_cnt <= '0;
    end else if (accept && (state == S_DATA)) begin
      ptr      <= ptr + 1'b1;
      csum     <= csum ^ in_data;
      byte_cnt <= byte_cnt_inc;
    end
  end

  // The array has no reset so a program survives a CPU/loader reset.
  always_ff @(posedge clk) begin
    if (!rst && accept && (state == S_DATA))
      mem[ptr] <= in_data;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a stream-level model tracks expected
// status and memory, checked against the DUT every cycle.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load_start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic [7:0] imem_addr = 8'h00;
  logic [7:0] imem_data;
  logic       cpu_rst, busy, done, error;
  logic [8:0] byte_count;

  always #5 clk = ~clk;

  imem_loader #(.INST_WIDTH(8), .INST_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .imem_addr(imem_addr),
    .imem_data(imem_data), .cpu_rst(cpu_rst), .busy(busy), .done(done),
    .error(error), .byte_count(byte_count)
  );

  int vectors = 0;
  int miscompares = 0;

  // Stream-level model
  logic [7:0] m_mem [256];
  bit         m_known [256];
  bit         m_loading = 0, m_need_len = 0, m_done = 0, m_error = 0;
  int         m_n = 0, m_idx = 0, m_bc = 0;
  logic [7:0] m_csum = 8'h00;
  bit         chk_en = 0;
  logic [7:0] sweep = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_edge(input bit r, input bit ls, input bit v, input logic [7:0] d);
    if (r) begin
      m_loading = 0; m_need_len = 0; m_done = 0; m_error = 0; m_bc = 0;
    end else if (!m_loading) begin
      if (ls) begin
        m_loading = 1; m_need_len = 1; m_done = 0; m_error = 0;
      end
    end else if (v) begin
      if (m_need_len) begin
        m_n = (d == 8'h00) ? 256 : int'(d);
        m_need_len = 0; m_idx = 0; m_csum = 8'h00; m_bc = 0;
      end else if (m_idx < m_n) begin
        m_mem[m_idx % 256] = d;
        m_known[m_idx % 256] = 1;
        m_csum = m_csum ^ d;
        m_idx++;
        m_bc = m_idx;
      end else begin
        m_loading = 0;
        if (d == m_csum) m_done = 1;
        else             m_error = 1;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",   int'(in_ready),   int'(m_loading));
      chk("busy",       int'(busy),       int'(m_loading));
      chk("done",       int'(done),       int'(m_done));
      chk("error",      int'(error),      int'(m_error));
      chk("cpu_rst",    int'(cpu_rst),    int'(!m_done));
      chk("byte_count", int'(byte_count), m_bc);
      if (m_known[imem_addr])
        chk("imem_data", int'(imem_data), int'(m_mem[imem_addr]));
    end
  end

  task automatic step(input bit r, input bit ls, input bit v, input logic [7:0] d);
    rst = r; load_start = ls; in_valid = v; in_data = d;
    imem_addr = sweep;
    sweep = sweep + 8'd37;
    @(posedge clk);
    model_edge(r, ls, v, d);
    #1;
  endtask

  task automatic send(input logic [7:0] bytes [$], input bit gap);
    foreach (bytes[i]) begin
      step(0, 0, 1, bytes[i]);
      if (gap) begin
        step(0, 0, 0, 8'hFF);
        step(0, 0, 0, 8'hFF);
      end
    end
  endtask

  task automatic peek(input string name, input logic [7:0] a, input logic [7:0] e);
    imem_addr = a;
    #1;
    chk(name, int'(imem_data), int'(e));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_known[i] = 0;

    step(1, 0, 0, 8'h00);
    chk_en = 1;
    step(1, 0, 0, 8'h00);
    chk("rst_cpu_rst", int'(cpu_rst), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_byte_count", int'(byte_count), 0);

    // Nominal load
    step(0, 1, 0, 8'h00);
    chk("t1_in_ready", int'(in_ready), 1);
    send('{8'h03, 8'h11, 8'hAE, 8'h22}, 0);
    chk("t1_cpu_rst_pre", int'(cpu_rst), 1);
    step(0, 0, 1, 8'h9D);
    chk("t1_cpu_rst_post", int'(cpu_rst), 0);
    chk("t1_done", int'(done), 1);
    chk("t1_error", int'(error), 0);
    chk("t1_byte_count", int'(byte_count), 3);
    peek("t1_mem0", 8'h00, 8'h11);
    peek("t1_mem1", 8'h01, 8'hAE);
    peek("t1_mem2", 8'h02, 8'h22);

    // Bad checksum, then ignored byte in ERR, then reload
    step(0, 1, 0, 8'h00);
    send('{8'h03, 8'h11, 8'hAE, 8'h22, 8'h00}, 0);
    chk("t2_error", int'(error), 1);
    chk("t2_done", int'(done), 0);
    chk("t2_cpu_rst", int'(cpu_rst), 1);
    chk("t2_in_ready", int'(in_ready), 0);
    step(0, 0, 1, 8'h77);
    chk("t2_err_hold", int'(error), 1);
    step(0, 1, 0, 8'h00);
    chk("t2_err_clear", int'(error), 0);
    chk("t2_reload_ready", int'(in_ready), 1);

    // Handshake gaps
    send('{8'h03, 8'h11, 8'hAE, 8'h22, 8'h9D}, 1);
    chk("t3_done", int'(done), 1);
    chk("t3_byte_count", int'(byte_count), 3);
    peek("t3_mem0", 8'h00, 8'h11);
    peek("t3_mem1", 8'h01, 8'hAE);
    peek("t3_mem2", 8'h02, 8'h22);
    peek("t3_mem3", 8'h03, m_mem[3]);

    // Full-length load
    step(0, 1, 0, 8'h00);
    step(0, 0, 1, 8'h00);
    for (int i = 0; i < 256; i++) step(0, 0, 1, 8'(i));
    chk("t4_busy_pre_csum", int'(busy), 1);
    step(0, 0, 1, 8'h00);
    chk("t4_byte_count", int'(byte_count), 256);
    chk("t4_done", int'(done), 1);
    peek("t4_memff", 8'hFF, 8'hFF);
    peek("t4_mem0", 8'h00, 8'h00);
    peek("t4_mem80", 8'h80, 8'h80);

    // Reload while running
    step(0, 1, 0, 8'h00);
    chk("t6_cpu_rst", int'(cpu_rst), 1);
    chk("t6_done", int'(done), 0);
    chk("t6_in_ready", int'(in_ready), 1);
    send('{8'h02, 8'h5A, 8'hC3, 8'h99}, 0);
    chk("t6_done_new", int'(done), 1);
    chk("t6_cpu_rst_new", int'(cpu_rst), 0);
    chk("t6_byte_count", int'(byte_count), 2);
    peek("t6_mem0", 8'h00, 8'h5A);
    peek("t6_mem1", 8'h01, 8'hC3);
    peek("t6_mem2", 8'h02, 8'h02);

    // Reset mid-load
    step(0, 1, 0, 8'h00);
    send('{8'h04, 8'hA1, 8'hB2}, 0);
    step(1, 0, 0, 8'h00);
    chk("t5_busy", int'(busy), 0);
    chk("t5_cpu_rst", int'(cpu_rst), 1);
    chk("t5_in_ready", int'(in_ready), 0);
    chk("t5_byte_count", int'(byte_count), 0);
    peek("t5_mem0", 8'h00, 8'hA1);
    peek("t5_mem1", 8'h01, 8'hB2);
    peek("t5_mem2", 8'h02, 8'h02);
    step(0, 0, 1, 8'h55);
    step(0, 0, 0, 8'h00);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program-image writer for the 8-bit CPU's instruction memory.
- Accepts a length-prefixed, XOR-checksummed byte stream over a valid/ready handshake and stores it in an internal 2^INST_DEPTH x INST_WIDTH array.
- Serves the array to the CPU fetch path via an asynchronous read port (imem_addr -> imem_data).
- Holds the CPU in reset until a load completes with a correct checksum.

Parameters:
- INST_WIDTH, 8, instruction/byte width; must match `INST_WIDTH.
- INST_DEPTH, 8, address width; the array holds 2^INST_DEPTH words; must match `INST_DEPTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- load_start  input  1  single-cycle request to begin a load.
- in_valid  input  1  in_data is valid this cycle.
- in_data  input  INST_WIDTH  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- imem_addr  input  INST_DEPTH  CPU fetch address.
- imem_data  output  INST_WIDTH  mem[imem_addr], combinational.
- cpu_rst  output  1  reset driven to the CPU (mcu/regs/pc).
- busy  output  1  load in progress.
- done  output  1  last load succeeded; CPU running.
- error  output  1  last load failed its checksum.
- byte_count  output  INST_DEPTH+1  data bytes written in the current or last load.

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset (rst=1 at an edge):
  - state=IDLE, cpu_rst=1, busy=0, done=0, error=0, byte_count=0, internal len/ptr/csum=0.
  - Memory array is not cleared; contents are retained across reset.
- Byte transfer: a byte is accepted at an edge where in_valid=1 and in_ready=1. in_ready is decoded from the state register only; it never depends on in_valid.
- Stream format: LEN byte, then N data bytes, then one CSUM byte.
  - N = LEN, except LEN=0 means N = 2^INST_DEPTH.
  - CSUM = XOR of all N data bytes.
- States:
  - IDLE: in_ready=0, cpu_rst=1. load_start -> LEN.
  - LEN: in_ready=1, busy=1. On accept, latch N, clear ptr/csum/byte_count -> DATA.
  - DATA: in_ready=1, busy=1. On accept: mem[ptr]<=in_data, csum^=in_data, ptr++ (wraps mod 2^INST_DEPTH), byte_count++. When byte_count reaches N on that accept -> CSUM.
  - CSUM: in_ready=1, busy=1. On accept: if in_data==csum -> RUN (done<=1), else -> ERR (error<=1).
  - RUN: in_ready=0, cpu_rst=0, done=1. load_start -> LEN.
  - ERR: in_ready=0, cpu_rst=1, error=1. load_start -> LEN.
- On entry to LEN from any state:
  - done<=0, error<=0.
  - cpu_rst<=1 in the same edge, so the CPU is reset from the next cycle.
- Latency:
  - The CSUM byte is accepted at edge k; cpu_rst is low from k+1.
  - After load_start at edge k in RUN, cpu_rst is high from k+1.
- load_start while in LEN/DATA/CSUM is ignored; the load continues.
- in_valid with in_ready=0 is ignored; no byte is consumed.
- A synchronous rst mid-load aborts: IDLE, cpu_rst=1. Bytes already written stay in memory.
- imem_data:
  - Always reflects mem[imem_addr] combinationally, including during a load.
  - A write at edge k is visible on imem_data after edge k.
- cpu_rst, busy, done, error are registered or decoded from registered state only; no combinational paths from inputs.

Test Plan:
1. Nominal load: rst 2 cycles, load_start. Stream 0x03, 0x11, 0xAE, 0x22, CSUM 0x9D, with in_valid=1 each cycle.
   - Required: done=1; error=0; byte_count=3.
   - cpu_rst falls the cycle after 0x9D is accepted.
   - imem_addr=0/1/2 reads 0x11/0xAE/0x22.
2. Bad checksum: same stream with CSUM=0x00.
   - Required: error=1, done=0, cpu_rst stays 1, in_ready=0.
   - A following load_start clears error and reloads.
3. Handshake gaps: repeat scenario 1 with in_valid toggling 1,0,0,1 and in_data=0xFF during invalid cycles.
   - Required: identical memory contents and CSUM result; no 0xFF written.
4. Full-length load: LEN=0x00, 256 data bytes with mem[i]=i, CSUM=0x00.
   - Required: byte_count=256, done=1, ptr wraps to 0, imem_addr=0xFF reads 0xFF.
5. Reset mid-load: after LEN=0x04 and two data bytes 0xA1, 0xB2, assert rst.
   - Required: next cycle IDLE, busy=0, cpu_rst=1, in_ready=0, mem[0]=0xA1, mem[1]=0xB2.
6. Reload while running: from RUN, pulse load_start.
   - Required: cpu_rst=1 and done=0 the next cycle; in_ready=1; a new image loads and reruns correctly.
